// File: rtl/writeback_unit.sv
// Register-file writeback: selects one of NSRC sources and drives a registered write port.
// Latency: one cycle for direct sources; memory source waits out BUSYWAIT (bounded by TIMEOUT).
// Backpressure: STALL asks upstream to hold its request while a memory load is outstanding.
module writeback_unit #(
    parameter int WIDTH    = 8,
    parameter int NSRC     = 4,
    parameter int SEL_W    = 2,
    parameter int RADDR_W  = 3,
    parameter int MEM_SRC  = 1,
    parameter int TIMEOUT  = 255,
    parameter int ZERO_REG = 0
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [NSRC*WIDTH-1:0]   SRC_DATA,
    input  logic [SEL_W-1:0]        WRITESEL,
    input  logic                    WRITEENABLE,
    input  logic [RADDR_W-1:0]      WRITEADDR,
    input  logic                    BUSYWAIT,
    output logic [WIDTH-1:0]        IN,
    output logic [RADDR_W-1:0]      INADDR,
    output logic                    INWRITE,
    output logic                    STALL,
    output logic                    ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_MEM = 1'b1;

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RADDR_W-1:0] r_pend_addr;
    logic [WIDTH-1:0]   r_in;
    logic [RADDR_W-1:0] r_inaddr;
    logic               r_inwrite;
    logic               r_err;

    logic [WIDTH-1:0]   w_sel_dat;
    logic [WIDTH-1:0]   w_mem_dat;
    logic               w_sel_ok;
    logic               w_sel_mem;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;
    logic               w_req_zero;
    logic               w_pend_zero;

    // Source mux; out-of-range selects yield zero and are flagged separately.
    always_comb begin
        w_sel_dat = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (int'(WRITESEL) == k) begin
                w_sel_dat = SRC_DATA[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_mem_dat   = SRC_DATA[MEM_SRC*WIDTH +: WIDTH];
    assign w_sel_ok    = (int'(WRITESEL) < NSRC);
    assign w_sel_mem   = (int'(WRITESEL) == MEM_SRC);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    // The edge on which the counter would reach TIMEOUT-1 is the last one we wait.
    assign w_timeout   = (int'(w_cnt_inc) >= (TIMEOUT - 1));
    assign w_req_zero  = (ZERO_REG != 0) && (WRITEADDR == '0);
    assign w_pend_zero = (ZERO_REG != 0) && (r_pend_addr == '0);

    // Stall covers the whole wait, including the cycle the blocked request is first presented.
    assign STALL = (r_state == S_WAIT_MEM) ||
                   (WRITEENABLE && w_sel_mem && BUSYWAIT);

    // FSM and registered write port; strobe defaults low so it is a single-cycle pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pend_addr <= '0;
            r_in        <= '0;
            r_inaddr    <= '0;
            r_inwrite   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_inwrite <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (WRITEENABLE) begin
                        if (!w_sel_ok) begin
                            r_err <= 1'b1;
                        end else if (w_sel_mem && BUSYWAIT) begin
                            r_pend_addr <= WRITEADDR;
                            r_cnt       <= '0;
                            r_state     <= S_WAIT_MEM;
                        end else begin
                            r_in      <= w_sel_dat;
                            r_inaddr  <= WRITEADDR;
                            r_inwrite <= !w_req_zero;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    // New requests are ignored here; upstream is holding on STALL.
                    if (!BUSYWAIT) begin
                        r_in      <= w_mem_dat;
                        r_inaddr  <= r_pend_addr;
                        r_inwrite <= !w_pend_zero;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign IN      = r_in;
    assign INADDR  = r_inaddr;
    assign INWRITE = r_inwrite;
    assign ERR     = r_err;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: scoreboard of expected writes popped as INWRITE pulses appear.
// Latency: checks one-cycle direct writes and bounded memory waits.
// Backpressure: STALL sampled directly against expected values.
module tb_writeback_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] src = '0;
    logic [1:0]  sel = '0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic        busy = 1'b0;

    logic [7:0] m_in;   logic [2:0] m_addr;  logic m_wr, m_stall, m_err;
    logic [7:0] t_in;   logic [2:0] t_addr;  logic t_wr, t_stall, t_err;
    logic [7:0] z_in;   logic [2:0] z_addr;  logic z_wr, z_stall, z_err;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] q_dat[$];
    logic [2:0] q_adr[$];

    always #5 CLK = ~CLK;

    writeback_unit #(.WIDTH(8), .NSRC(4), .SEL_W(2), .RADDR_W(3), .MEM_SRC(1),
                     .TIMEOUT(4), .ZERO_REG(0)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .SRC_DATA(src), .WRITESEL(sel),
        .WRITEENABLE(we), .WRITEADDR(addr), .BUSYWAIT(busy),
        .IN(m_in), .INADDR(m_addr), .INWRITE(m_wr), .STALL(m_stall), .ERR(m_err));

    writeback_unit #(.WIDTH(8), .NSRC(3), .SEL_W(2), .RADDR_W(3), .MEM_SRC(1),
                     .TIMEOUT(4), .ZERO_REG(0)) u_dut3 (
        .CLK(CLK), .RESET_N(RESET_N), .SRC_DATA(src[23:0]), .WRITESEL(sel),
        .WRITEENABLE(we), .WRITEADDR(addr), .BUSYWAIT(busy),
        .IN(t_in), .INADDR(t_addr), .INWRITE(t_wr), .STALL(t_stall), .ERR(t_err));

    writeback_unit #(.WIDTH(8), .NSRC(4), .SEL_W(2), .RADDR_W(3), .MEM_SRC(1),
                     .TIMEOUT(4), .ZERO_REG(1)) u_dutz (
        .CLK(CLK), .RESET_N(RESET_N), .SRC_DATA(src), .WRITESEL(sel),
        .WRITEENABLE(we), .WRITEADDR(addr), .BUSYWAIT(busy),
        .IN(z_in), .INADDR(z_addr), .INWRITE(z_wr), .STALL(z_stall), .ERR(z_err));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] a);
        q_dat.push_back(d);
        q_adr.push_back(a);
    endtask

    // Every write pulse on the main instance must match the oldest expected write.
    always @(negedge CLK) begin
        if (m_wr === 1'b1) begin
            if (q_dat.size() == 0) begin
                check("unexpected_write", 32'(m_addr), 32'hFFFF_FFFF);
            end else begin
                check("wr_data", 32'(m_in), 32'(q_dat.pop_front()));
                check("wr_addr", 32'(m_addr), 32'(q_adr.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        step();
        step();
        #1;
        check("rst_in", 32'(m_in), 0);
        check("rst_inaddr", 32'(m_addr), 0);
        check("rst_inwrite", 32'(m_wr), 0);
        check("rst_err", 32'(m_err), 0);
        check("rst_stall", 32'(m_stall), 0);
        RESET_N = 1'b1;

        // Simple direct write right after reset release
        step();
        we = 1'b1; sel = 2'd0; src[7:0] = 8'h5A; addr = 3'd3; busy = 1'b0;
        push(8'h5A, 3'd3);
        #1 check("t1_stall", 32'(m_stall), 0);
        step();
        we = 1'b0;
        step();
        #1;
        check("t1_pulse_end", 32'(m_wr), 0);
        check("t1_hold_in", 32'(m_in), 32'h5A);
        check("t1_hold_addr", 32'(m_addr), 3);

        // Memory load with two busy cycles; a request during the wait is ignored
        we = 1'b1; sel = 2'd1; addr = 3'd6; busy = 1'b1;
        push(8'hC3, 3'd6);
        #1 check("t2_stall_c0", 32'(m_stall), 1);
        step();
        sel = 2'd2; addr = 3'd7; src[23:16] = 8'h99;
        #1 check("t2_stall_c1", 32'(m_stall), 1);
        step();
        busy = 1'b0; src[15:8] = 8'hC3;
        #1 check("t2_stall_c2", 32'(m_stall), 1);
        step();
        we = 1'b0;
        #1 check("t2_stall_done", 32'(m_stall), 0);
        check("t2_err", 32'(m_err), 0);

        // Memory timeout: four edges including the accepting one
        we = 1'b1; sel = 2'd1; addr = 3'd2; busy = 1'b1;
        step();
        we = 1'b0;
        step();
        step();
        #1;
        check("t3_err_early", 32'(m_err), 0);
        check("t3_stall_wait", 32'(m_stall), 1);
        step();
        #1;
        check("t3_err_set", 32'(m_err), 1);
        check("t3_stall_idle", 32'(m_stall), 0);
        busy = 1'b0;
        step();
        #1 check("t3_no_late_wr", 32'(m_wr), 0);

        // Back-to-back direct writes; error flag stays set without blocking
        we = 1'b1; sel = 2'd3; src[31:24] = 8'h11; addr = 3'd4;
        push(8'h11, 3'd4);
        step();
        sel = 2'd2; src[23:16] = 8'h22; addr = 3'd5;
        push(8'h22, 3'd5);
        #1 check("t4_first_wr", 32'(m_wr), 1);
        step();
        we = 1'b0;
        #1 check("t4_second_wr", 32'(m_wr), 1);
        check("t4_err_sticky", 32'(m_err), 1);
        step();

        // Out-of-range select on the NSRC=3 instance
        RESET_N = 1'b0;
        #1;
        check("t5_err_cleared", 32'(m_err), 0);
        check("t5_dut3_err_cleared", 32'(t_err), 0);
        RESET_N = 1'b1;
        step();
        we = 1'b1; sel = 2'd3; src[31:24] = 8'h33; addr = 3'd1;
        push(8'h33, 3'd1);
        step();
        we = 1'b0;
        #1;
        check("t5_dut3_err", 32'(t_err), 1);
        check("t5_dut3_nowr", 32'(t_wr), 0);
        check("t5_main_err", 32'(m_err), 0);

        // Writes to register 0 suppressed on the ZERO_REG instance
        step();
        we = 1'b1; sel = 2'd0; src[7:0] = 8'h77; addr = 3'd5;
        push(8'h77, 3'd5);
        step();
        addr = 3'd0; src[7:0] = 8'h88;
        push(8'h88, 3'd0);
        #1;
        check("t6_z_wr5", 32'(z_wr), 1);
        check("t6_z_addr5", 32'(z_addr), 5);
        step();
        we = 1'b0;
        #1;
        check("t6_z_wr0", 32'(z_wr), 0);
        check("t6_z_addr0", 32'(z_addr), 0);
        check("t6_z_in", 32'(z_in), 32'h88);

        // Reset during a memory wait abandons the load
        step();
        we = 1'b1; sel = 2'd1; addr = 3'd3; busy = 1'b1; src[15:8] = 8'hEE;
        step();
        we = 1'b0;
        #1 check("t7_stall_wait", 32'(m_stall), 1);
        RESET_N = 1'b0;
        #1;
        check("t7_async_stall", 32'(m_stall), 0);
        check("t7_async_in", 32'(m_in), 0);
        check("t7_async_wr", 32'(m_wr), 0);
        step();
        RESET_N = 1'b1;
        step();
        busy = 1'b0;
        step();
        step();
        #1;
        check("t7_no_wr", 32'(m_wr), 0);
        check("t7_stall_idle", 32'(m_stall), 0);

        check("sb_drained", 32'(q_dat.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
